// File: rtl/i2lbs_pixel_feeder.sv
// i2lbs_pixel_feeder: buffers camera pixels in a FIFO, stamps raster coordinates
// and issues them to I2LBS with a one-cycle strobe while it requests pixels.
module i2lbs_pixel_feeder #(
  parameter int DATA_WIDTH_12                = 12,
  parameter int DATA_WIDTH_16                = 16,
  parameter int FRAME_ORIGINAL_CAMERA_WIDTH  = 10,
  parameter int FRAME_ORIGINAL_CAMERA_HEIGHT = 10,
  parameter int FIFO_DEPTH                   = 8,
  parameter int FIFO_ADDR_WIDTH              = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_pixel_valid,
  input  logic [DATA_WIDTH_16-1:0] i_pixel,
  input  logic                     i_frame_start,
  input  logic                     i_pixel_request,
  output logic                     o_ready,
  output logic [DATA_WIDTH_16-1:0] o_pixel,
  output logic [DATA_WIDTH_12-1:0] o_ori_x,
  output logic [DATA_WIDTH_12-1:0] o_ori_y,
  output logic                     o_enable_recieve_pixel,
  output logic                     o_frame_done,
  output logic                     o_overflow
);
  localparam int CW = FIFO_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] L_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH_12-1:0] L_XMAX = DATA_WIDTH_12'(FRAME_ORIGINAL_CAMERA_WIDTH - 1);
  localparam logic [DATA_WIDTH_12-1:0] L_YMAX = DATA_WIDTH_12'(FRAME_ORIGINAL_CAMERA_HEIGHT - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t                     r_state, w_state_next;
  logic [DATA_WIDTH_16-1:0]   r_mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] r_wptr, r_rptr, w_waddr;
  logic [CW-1:0]              r_count;
  logic [DATA_WIDTH_12-1:0]   r_x_cnt, r_y_cnt, r_ori_x, r_ori_y;
  logic [DATA_WIDTH_16-1:0]   r_pixel;
  logic                       r_strobe, r_frame_done, r_overflow;
  logic                       w_empty, w_full, w_pop, w_push, w_last_x, w_last_y;

  assign w_empty  = r_count == '0;
  assign w_full   = r_count == L_DEPTH;
  assign w_pop    = r_state == S_IDLE && i_pixel_request && !w_empty && !i_frame_start;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push   = i_pixel_valid && (i_frame_start || !w_full || w_pop);
  assign w_waddr  = i_frame_start ? '0 : r_wptr;
  assign w_last_x = r_x_cnt == L_XMAX;
  assign w_last_y = r_y_cnt == L_YMAX;

  assign o_ready                = !w_full && reset;
  assign o_pixel                = r_pixel;
  assign o_ori_x                = r_ori_x;
  assign o_ori_y                = r_ori_y;
  assign o_enable_recieve_pixel = r_strobe;
  assign o_frame_done           = r_frame_done;
  assign o_overflow             = r_overflow;

  always_comb begin
    w_state_next = S_IDLE;
    if (!i_frame_start && r_state == S_IDLE) w_state_next = w_pop ? S_HOLD : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_waddr] <= i_pixel;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_frame_start) begin
      r_wptr  <= FIFO_ADDR_WIDTH'(w_push);
      r_rptr  <= '0;
      r_count <= CW'(w_push);
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_ADDR_WIDTH'(1);
      if (w_pop)  r_rptr <= r_rptr + FIFO_ADDR_WIDTH'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pixel      <= '0;
      r_ori_x      <= '0;
      r_ori_y      <= '0;
      r_x_cnt      <= '0;
      r_y_cnt      <= '0;
      r_strobe     <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (i_frame_start) begin
      r_x_cnt      <= '0;
      r_y_cnt      <= '0;
      r_strobe     <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (i_pixel_valid && !w_push) r_overflow <= 1'b1;
      if (r_state == S_IDLE) begin
        r_strobe <= w_pop;
        if (w_pop) begin
          r_pixel <= r_mem[r_rptr];
          r_ori_x <= r_x_cnt;
          r_ori_y <= r_y_cnt;
        end
      end else begin
        // counters still hold the issued pixel's coordinates during HOLD
        r_strobe     <= 1'b0;
        r_frame_done <= w_last_x && w_last_y;
        r_x_cnt      <= w_last_x ? '0 : r_x_cnt + DATA_WIDTH_12'(1);
        if (w_last_x) r_y_cnt <= w_last_y ? '0 : r_y_cnt + DATA_WIDTH_12'(1);
      end
    end
  end
endmodule

// File: tb/tb_i2lbs_pixel_feeder.sv
// tb_i2lbs_pixel_feeder: directed self-checking bench for the I2LBS pixel feeder.
module tb_i2lbs_pixel_feeder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_pixel_valid = 1'b0;
  logic [15:0] i_pixel = '0;
  logic        i_frame_start = 1'b0;
  logic        i_pixel_request = 1'b0;
  logic        o_ready;
  logic [15:0] o_pixel;
  logic [11:0] o_ori_x, o_ori_y;
  logic        o_enable_recieve_pixel, o_frame_done, o_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] q_pix[$];
  int q_x[$], q_y[$], q_cyc[$];
  int cyc = 0, fd_cnt = 0, fd_cyc = 0, wide = 0;
  bit prev_stb = 1'b0;

  i2lbs_pixel_feeder dut (
    .clk(clk), .reset(reset), .i_pixel_valid(i_pixel_valid), .i_pixel(i_pixel),
    .i_frame_start(i_frame_start), .i_pixel_request(i_pixel_request), .o_ready(o_ready),
    .o_pixel(o_pixel), .o_ori_x(o_ori_x), .o_ori_y(o_ori_y),
    .o_enable_recieve_pixel(o_enable_recieve_pixel), .o_frame_done(o_frame_done),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_enable_recieve_pixel) begin
      q_pix.push_back(o_pixel);
      q_x.push_back(int'(o_ori_x));
      q_y.push_back(int'(o_ori_y));
      q_cyc.push_back(cyc);
      if (prev_stb) wide++;
    end
    if (o_frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    prev_stb = o_enable_recieve_pixel;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] pix, input bit fs);
    i_pixel_valid = 1'b1;
    i_pixel       = pix;
    i_frame_start = fs;
    tick();
    i_pixel_valid = 1'b0;
    i_frame_start = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget);
    int i = 0;
    while (q_pix.size() < n && i < budget) begin
      tick();
      i++;
    end
    chk("wait_strobes", 32'(q_pix.size() >= n), 1);
  endtask

  task automatic chk_item(input string tag, input int idx, input int pix, input int x, input int y);
    if (idx < q_pix.size()) begin
      chk(tag, 32'(q_pix[idx]), pix);
      chk(tag, q_x[idx] * 256 + q_y[idx], x * 256 + y);
    end else chk(tag, 32'(q_pix.size()), idx + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, f0, b2;
    repeat (3) tick();
    chk("rst_out", {o_pixel, o_ori_x, o_ori_y} == '0, 1);
    chk("rst_flags", {o_enable_recieve_pixel, o_frame_done, o_overflow, o_ready}, 0);
    reset = 1'b1;
    #1;
    chk("rst_ready", o_ready, 1);

    // basic frame, 1 pixel per 4 cycles
    i_pixel_request = 1'b1;
    b  = q_pix.size();
    f0 = fd_cnt;
    push(16'd0, 1'b1);
    chk("lat_n", o_enable_recieve_pixel, 0);
    tick();
    chk("lat_n1", o_enable_recieve_pixel, 1);
    chk("lat_n1_pix", o_pixel, 0);
    tick();
    chk("lat_n2", o_enable_recieve_pixel, 0);
    tick();
    for (int k = 1; k < 100; k++) begin
      push(16'(k), 1'b0);
      repeat (3) tick();
    end
    repeat (6) tick();
    chk("frame_cnt", q_pix.size() - b, 100);
    for (int k = 0; k < 100; k++) chk_item("frame_px", b + k, k, k % 10, k / 10);
    chk("frame_done_cnt", fd_cnt - f0, 1);
    if (b + 99 < q_cyc.size()) chk("frame_done_pos", fd_cyc - q_cyc[b + 99], 1);

    // backpressure
    i_pixel_request = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) chk("bp_rdy_before", o_ready, 1);
      push(16'(k), k == 1);
    end
    chk("bp_rdy_full", o_ready, 0);
    chk("bp_ovf_clear", o_overflow, 0);
    push(16'd9, 1'b0);
    chk("bp_ovf_set", o_overflow, 1);
    b = q_pix.size();
    i_pixel_request = 1'b1;
    wait_q(b + 8, 40);
    repeat (4) tick();
    chk("bp_cnt", q_pix.size() - b, 8);
    for (int k = 0; k < 8; k++) begin
      chk_item("bp_px", b + k, k + 1, k, 0);
      if (k > 0 && b + k < q_cyc.size()) chk("bp_rate", q_cyc[b + k] - q_cyc[b + k - 1], 2);
    end

    // full FIFO with simultaneous push and pop
    i_pixel_request = 1'b0;
    for (int k = 0; k < 8; k++) push(16'h100 + 16'(k), k == 0);
    chk("fp_full", o_ready, 0);
    b = q_pix.size();
    i_pixel_request = 1'b1;
    push(16'h1FF, 1'b0);
    chk("fp_ovf", o_overflow, 0);
    chk("fp_count8", o_ready, 0);
    chk("fp_stb", o_enable_recieve_pixel, 1);
    chk("fp_head", o_pixel, 16'h100);
    wait_q(b + 9, 40);
    repeat (4) tick();
    chk("fp_cnt", q_pix.size() - b, 9);
    chk_item("fp_last", b + 8, 16'h1FF, 8, 0);
    chk("fp_ovf_end", o_overflow, 0);

    // mid-frame resync
    f0 = fd_cnt;
    b  = q_pix.size();
    push(16'd0, 1'b1);
    repeat (3) tick();
    for (int k = 1; k < 37; k++) begin
      push(16'(k), 1'b0);
      repeat (3) tick();
    end
    wait_q(b + 37, 20);
    chk("rs_cnt", q_pix.size() - b, 37);
    i_pixel_request = 1'b0;
    for (int k = 0; k < 9; k++) push(16'h200 + 16'(k), 1'b0);
    chk("rs_ovf_set", o_overflow, 1);
    push(16'hABCD, 1'b1);
    chk("rs_ovf_clr", o_overflow, 0);
    chk("rs_rdy", o_ready, 1);
    b2 = q_pix.size();
    i_pixel_request = 1'b1;
    repeat (10) tick();
    chk("rs_flush", q_pix.size() - b2, 1);
    chk_item("rs_px", b2, 16'hABCD, 0, 0);
    chk("rs_no_done", fd_cnt - f0, 0);

    // rollover, 1 pixel per 2 cycles
    f0 = fd_cnt;
    b  = q_pix.size();
    push(16'd0, 1'b1);
    tick();
    for (int k = 1; k <= 100; k++) begin
      push(16'(k), 1'b0);
      tick();
    end
    repeat (6) tick();
    chk("ro_cnt", q_pix.size() - b, 101);
    chk_item("ro_99", b + 99, 99, 9, 9);
    chk_item("ro_100", b + 100, 100, 0, 0);
    chk("ro_done_cnt", fd_cnt - f0, 1);
    if (b + 100 < q_cyc.size()) chk("ro_done_pos", q_cyc[b + 100] - fd_cyc, 1);

    // reset during HOLD
    i_pixel_request = 1'b0;
    for (int k = 0; k < 4; k++) push(16'h300 + 16'(k), k == 0);
    i_pixel_request = 1'b1;
    tick();
    chk("rh_stb", o_enable_recieve_pixel, 1);
    reset = 1'b0;
    tick();
    chk("rh_out", {o_pixel, o_ori_x, o_ori_y} == '0, 1);
    chk("rh_flags", {o_enable_recieve_pixel, o_frame_done, o_overflow, o_ready}, 0);
    b = q_pix.size();
    reset = 1'b1;
    #1;
    chk("rh_rdy", o_ready, 1);
    repeat (10) tick();
    chk("rh_quiet", q_pix.size() - b, 0);
    push(16'h3AA, 1'b0);
    repeat (3) tick();
    chk("rh_new_cnt", q_pix.size() - b, 1);
    chk_item("rh_new", b, 16'h3AA, 0, 0);

    chk("strobe_width", wide, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
